// File: rtl/dds_wave_ctrl_if.sv
// Configuration handshake bundle for dds_wave_ctrl: frequency word, phase offset
// and waveform select offered with a valid/ready pair.
interface dds_wave_ctrl_if #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 10
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [PHASE_WIDTH-1:0] cfg_freq_word;
  logic [ADDR_WIDTH-1:0]  cfg_phase_off;
  logic [1:0]             cfg_wave_sel;

  modport master (
    output cfg_valid, cfg_freq_word, cfg_phase_off, cfg_wave_sel,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_freq_word, cfg_phase_off, cfg_wave_sel,
    output cfg_ready
  );
endinterface

// File: rtl/dds_wave_ctrl.sv
// DDS phase-accumulator controller: drives the shared waveform ROM address and
// selects the returned sample; new configuration takes effect at period boundaries.
module dds_wave_ctrl #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  dds_wave_ctrl_if.slave        cfg,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rst,
  input  logic [DATA_WIDTH-1:0] rom_data_sin,
  input  logic [DATA_WIDTH-1:0] rom_data_squ,
  input  logic [DATA_WIDTH-1:0] rom_data_tri,
  input  logic [DATA_WIDTH-1:0] rom_data_saw,
  output logic [DATA_WIDTH-1:0] wave_out,
  output logic                  wave_valid,
  output logic                  period_start
);

  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PEND
  } state_t;

  state_t                 state, state_nxt;
  logic [PHASE_WIDTH-1:0] acc, acc_sum;
  logic                   carry;
  logic [PHASE_WIDTH-1:0] freq_word, sh_freq_word;
  logic [ADDR_WIDTH-1:0]  phase_off, sh_phase_off;
  logic [1:0]             wave_sel, sh_wave_sel;
  logic                   pending;
  logic                   wrap_seen;
  logic                   xfer;
  logic                   issue, ld_direct, set_pending, apply_shadow;

  logic                   iss_valid, iss_wrap;
  logic [1:0]             iss_sel;
  logic [ROM_LATENCY-1:0] dly_valid, dly_wrap;
  logic [1:0]             dly_sel [ROM_LATENCY];
  logic [DATA_WIDTH-1:0]  sample;

  assign rom_rst       = ~rst_n;
  assign cfg.cfg_ready = ~pending;
  assign xfer          = cfg.cfg_valid & ~pending;
  assign {carry, acc_sum} = {1'b0, acc} + {1'b0, freq_word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    ld_direct    = 1'b0;
    set_pending  = 1'b0;
    apply_shadow = 1'b0;
    case (state)
      ST_IDLE: begin
        ld_direct = xfer;
        if (en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          ld_direct = xfer;
          state_nxt = ST_IDLE;
        end else begin
          issue = 1'b1;
          if (xfer) begin
            set_pending = 1'b1;
            state_nxt   = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (!en) begin
          apply_shadow = 1'b1;
          state_nxt    = ST_IDLE;
        end else begin
          issue = 1'b1;
          // A zero increment never wraps, so the shadow would otherwise wait forever.
          if (carry || freq_word == '0) begin
            apply_shadow = 1'b1;
            state_nxt    = ST_RUN;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_word    <= '0;
      phase_off    <= '0;
      wave_sel     <= '0;
      sh_freq_word <= '0;
      sh_phase_off <= '0;
      sh_wave_sel  <= '0;
      pending      <= 1'b0;
      acc          <= '0;
      wrap_seen    <= 1'b0;
      rom_addr     <= '0;
      iss_valid    <= 1'b0;
      iss_wrap     <= 1'b0;
      iss_sel      <= '0;
    end else begin
      if (ld_direct) begin
        freq_word <= cfg.cfg_freq_word;
        phase_off <= cfg.cfg_phase_off;
        wave_sel  <= cfg.cfg_wave_sel;
      end else if (apply_shadow) begin
        freq_word <= sh_freq_word;
        phase_off <= sh_phase_off;
        wave_sel  <= sh_wave_sel;
      end
      if (xfer) begin
        sh_freq_word <= cfg.cfg_freq_word;
        sh_phase_off <= cfg.cfg_phase_off;
        sh_wave_sel  <= cfg.cfg_wave_sel;
      end
      if (set_pending)       pending <= 1'b1;
      else if (apply_shadow) pending <= 1'b0;
      acc <= issue ? acc_sum : '0;
      // Marks the next issued sample as a period start; held set while idle so
      // the first sample after start-up is flagged too.
      wrap_seen <= issue ? carry : 1'b1;
      rom_addr  <= issue ? acc[PHASE_WIDTH-1 -: ADDR_WIDTH] + phase_off : phase_off;
      iss_valid <= issue;
      iss_wrap  <= issue & wrap_seen;
      iss_sel   <= wave_sel;
    end
  end

  // Select and flags travel alongside the ROM read so each sample keeps its own config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_valid <= '0;
      dly_wrap  <= '0;
      for (int unsigned i = 0; i < ROM_LATENCY; i++) dly_sel[i] <= '0;
    end else begin
      dly_valid[0] <= iss_valid;
      dly_wrap[0]  <= iss_wrap;
      dly_sel[0]   <= iss_sel;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        dly_valid[i] <= dly_valid[i-1];
        dly_wrap[i]  <= dly_wrap[i-1];
        dly_sel[i]   <= dly_sel[i-1];
      end
    end
  end

  always_comb begin
    sample = rom_data_sin;
    case (dly_sel[ROM_LATENCY-1])
      2'd1:    sample = rom_data_squ;
      2'd2:    sample = rom_data_tri;
      2'd3:    sample = rom_data_saw;
      default: sample = rom_data_sin;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_out     <= MIDSCALE;
      wave_valid   <= 1'b0;
      period_start <= 1'b0;
    end else begin
      wave_out     <= dly_valid[ROM_LATENCY-1] ? sample : MIDSCALE;
      wave_valid   <= dly_valid[ROM_LATENCY-1];
      period_start <= dly_valid[ROM_LATENCY-1] & dly_wrap[ROM_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_dds_wave_ctrl.sv
// Directed bench for dds_wave_ctrl: vector table for start-up cases plus
// hand-written sequences for period boundaries, pending config, stop and reset.
module tb_dds_wave_ctrl;
  localparam int unsigned PW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned RL = 1;

  localparam logic [31:0] F22 = 32'h0040_0000;
  localparam logic [31:0] F23 = 32'h0080_0000;
  localparam logic [31:0] F24 = 32'h0100_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [AW-1:0] rom_addr;
  logic          rom_rst;
  logic [DW-1:0] sin_q, squ_q, tri_q, saw_q;
  logic [DW-1:0] wave_out;
  logic          wave_valid;
  logic          period_start;

  int total = 0;
  int bad   = 0;

  dds_wave_ctrl_if #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW)) cfg_if ();

  dds_wave_ctrl #(
    .PHASE_WIDTH(PW),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ROM_LATENCY(RL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg         (cfg_if),
    .rom_addr    (rom_addr),
    .rom_rst     (rom_rst),
    .rom_data_sin(sin_q),
    .rom_data_squ(squ_q),
    .rom_data_tri(tri_q),
    .rom_data_saw(saw_q),
    .wave_out    (wave_out),
    .wave_valid  (wave_valid),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Synthetic ROM contents chosen so the four waveforms differ at most addresses.
  function automatic logic [7:0] f_sin(input logic [9:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] f_squ(input logic [9:0] a);
    return a[9] ? 8'h00 : 8'hFF;
  endfunction
  function automatic logic [7:0] f_tri(input logic [9:0] a);
    return a[9] ? ~a[8:1] : a[8:1];
  endfunction
  function automatic logic [7:0] f_saw(input logic [9:0] a);
    return a[9:2] ^ 8'h3C;
  endfunction

  always_ff @(posedge clk or posedge rom_rst) begin
    if (rom_rst) begin
      sin_q <= '0;
      squ_q <= '0;
      tri_q <= '0;
      saw_q <= '0;
    end else begin
      sin_q <= f_sin(rom_addr);
      squ_q <= f_squ(rom_addr);
      tri_q <= f_tri(rom_addr);
      saw_q <= f_saw(rom_addr);
    end
  end

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        valid;
    logic [31:0] freq;
    logic [9:0]  off;
    logic [1:0]  sel;
    logic [9:0]  e_addr;
    logic        e_valid;
    logic        e_ps;
    logic [7:0]  e_out;
    logic        e_ready;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic e, input logic v,
                              input logic [31:0] f, input logic [9:0] o, input logic [1:0] s,
                              input logic [9:0] ea, input logic ev, input logic eps,
                              input logic [7:0] eo, input logic er);
    vec_t t;
    t.rst_n = r;  t.en = e;  t.valid = v;  t.freq = f;  t.off = o;  t.sel = s;
    t.e_addr = ea; t.e_valid = ev; t.e_ps = eps; t.e_out = eo; t.e_ready = er;
    tbl.push_back(t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_cfg(input logic v, input logic [31:0] f, input logic [9:0] o,
                           input logic [1:0] s);
    cfg_if.cfg_valid     = v;
    cfg_if.cfg_freq_word = f;
    cfg_if.cfg_phase_off = o;
    cfg_if.cfg_wave_sel  = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    drive_cfg(1'b0, '0, '0, '0);
    step();
    rst_n = 1'b1;
  endtask

  // Loads config while idle, then raises en; returns just after the en edge.
  task automatic start_run(input logic [31:0] f, input logic [9:0] o, input logic [1:0] s);
    drive_cfg(1'b1, f, o, s);
    step();
    drive_cfg(1'b0, f, o, s);
    en = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    en    = 1'b0;
    drive_cfg(1'b0, '0, '0, '0);

    // Start-up with sine, step 1
    add(0,0,0,'0 ,0,0,  0,   0,0,8'h80,1);
    add(1,0,1,F22,0,0,  0,   0,0,8'h80,1);
    add(1,1,0,F22,0,0,  0,   0,0,8'h80,1);
    add(1,1,0,F22,0,0,  0,   0,0,8'h80,1);
    add(1,1,0,F22,0,0,  1,   0,0,8'h80,1);
    add(1,1,0,F22,0,0,  2,   1,1,8'hA5,1);
    add(1,1,0,F22,0,0,  3,   1,0,8'hA4,1);
    add(1,1,0,F22,0,0,  4,   1,0,8'hA7,1);
    add(1,1,0,F22,0,0,  5,   1,0,8'hA6,1);
    // Phase offset 1020: address wraps without an acc wrap
    add(0,0,0,'0 ,0,0,  0,   0,0,8'h80,1);
    add(1,0,1,F22,1020,0, 0, 0,0,8'h80,1);
    add(1,1,0,F22,1020,0, 1020,0,0,8'h80,1);
    add(1,1,0,F22,1020,0, 1020,0,0,8'h80,1);
    add(1,1,0,F22,1020,0, 1021,0,0,8'h80,1);
    add(1,1,0,F22,1020,0, 1022,1,1,8'h59,1);
    add(1,1,0,F22,1020,0, 1023,1,0,8'h58,1);
    add(1,1,0,F22,1020,0, 0,   1,0,8'h5B,1);
    add(1,1,0,F22,1020,0, 1,   1,0,8'h5A,1);
    add(1,1,0,F22,1020,0, 2,   1,0,8'hA5,1);
    add(1,1,0,F22,1020,0, 3,   1,0,8'hA4,1);
    // Triangle, step 2
    add(0,0,0,'0 ,0,0,  0,   0,0,8'h80,1);
    add(1,0,1,F23,0,2,  0,   0,0,8'h80,1);
    add(1,1,0,F23,0,2,  0,   0,0,8'h80,1);
    add(1,1,0,F23,0,2,  0,   0,0,8'h80,1);
    add(1,1,0,F23,0,2,  2,   0,0,8'h80,1);
    add(1,1,0,F23,0,2,  4,   1,1,8'h00,1);
    add(1,1,0,F23,0,2,  6,   1,0,8'h01,1);
    add(1,1,0,F23,0,2,  8,   1,0,8'h02,1);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      en    = tbl[i].en;
      drive_cfg(tbl[i].valid, tbl[i].freq, tbl[i].off, tbl[i].sel);
      step();
      chk($sformatf("vec%0d rom_addr", i),   32'(rom_addr),        32'(tbl[i].e_addr));
      chk($sformatf("vec%0d wave_valid", i), 32'(wave_valid),      32'(tbl[i].e_valid));
      chk($sformatf("vec%0d period_start", i), 32'(period_start),  32'(tbl[i].e_ps));
      chk($sformatf("vec%0d wave_out", i),   32'(wave_out),        32'(tbl[i].e_out));
      chk($sformatf("vec%0d cfg_ready", i),  32'(cfg_if.cfg_ready), 32'(tbl[i].e_ready));
    end

    // Two full periods: period_start every 1024 samples
    do_reset();
    start_run(F22, 10'd0, 2'd0);
    for (int k = 1; k <= 2060; k++) begin
      step();
      chk($sformatf("per k%0d rom_addr", k), 32'(rom_addr), 32'((k - 1) % 1024));
      if (k >= 3) begin
        chk($sformatf("per s%0d valid", k - 3), 32'(wave_valid), 32'd1);
        chk($sformatf("per s%0d period_start", k - 3), 32'(period_start),
            32'(((k - 3) % 1024) == 0));
        chk($sformatf("per s%0d wave_out", k - 3), 32'(wave_out),
            32'(f_sin(10'((k - 3) % 1024))));
      end
    end

    // Mid-period config: held in shadow until the accumulator wraps
    do_reset();
    start_run(F22, 10'd0, 2'd0);
    repeat (501) step();
    chk("mid start addr", 32'(rom_addr), 32'd500);
    drive_cfg(1'b1, F23, 10'd0, 2'd1);
    chk("mid ready before", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    drive_cfg(1'b0, F23, 10'd0, 2'd1);
    chk("mid xfer addr", 32'(rom_addr), 32'd501);
    chk("mid ready pending", 32'(cfg_if.cfg_ready), 32'd0);
    for (int a = 502; a <= 1022; a++) begin
      step();
      chk($sformatf("mid a%0d rom_addr", a), 32'(rom_addr), 32'(a));
      chk($sformatf("mid a%0d cfg_ready", a), 32'(cfg_if.cfg_ready), 32'd0);
    end
    step();
    chk("mid wrap addr", 32'(rom_addr), 32'd1023);
    chk("mid wrap ready", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    chk("mid new addr0", 32'(rom_addr), 32'd0);
    chk("mid out s1022", 32'(wave_out), 32'h5B);
    step();
    chk("mid new addr2", 32'(rom_addr), 32'd2);
    chk("mid out s1023", 32'(wave_out), 32'h5A);
    chk("mid ps s1023", 32'(period_start), 32'd0);
    step();
    chk("mid new addr4", 32'(rom_addr), 32'd4);
    chk("mid out square0", 32'(wave_out), 32'hFF);
    chk("mid ps square0", 32'(period_start), 32'd1);
    step();
    chk("mid out square2", 32'(wave_out), 32'hFF);
    chk("mid ps square2", 32'(period_start), 32'd0);

    // Zero frequency: pending config applies on the following cycle
    do_reset();
    start_run('0, 10'd0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("f0 hold%0d addr", k), 32'(rom_addr), 32'd0);
    end
    drive_cfg(1'b1, F22, 10'd0, 2'd0);
    chk("f0 ready before", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    drive_cfg(1'b0, F22, 10'd0, 2'd0);
    chk("f0 ready pending", 32'(cfg_if.cfg_ready), 32'd0);
    step();
    chk("f0 ready applied", 32'(cfg_if.cfg_ready), 32'd1);
    chk("f0 addr apply", 32'(rom_addr), 32'd0);
    step();
    chk("f0 addr t2", 32'(rom_addr), 32'd0);
    step();
    chk("f0 addr t3", 32'(rom_addr), 32'd1);
    step();
    chk("f0 addr t4", 32'(rom_addr), 32'd2);

    // Asynchronous reset mid-run with a pending config
    do_reset();
    start_run(F22, 10'd0, 2'd0);
    repeat (20) step();
    drive_cfg(1'b1, F23, 10'd3, 2'd1);
    step();
    drive_cfg(1'b0, F23, 10'd3, 2'd1);
    chk("rst ready pending", 32'(cfg_if.cfg_ready), 32'd0);
    repeat (3) step();
    chk("rst pre valid", 32'(wave_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("rst rom_addr", 32'(rom_addr), 32'd0);
    chk("rst wave_out", 32'(wave_out), 32'h80);
    chk("rst wave_valid", 32'(wave_valid), 32'd0);
    chk("rst period_start", 32'(period_start), 32'd0);
    chk("rst cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("rst rom_rst", 32'(rom_rst), 32'd1);
    #2;
    rst_n = 1'b1;
    step();
    chk("rst after ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("rst after addr", 32'(rom_addr), 32'd0);
    chk("rst after valid", 32'(wave_valid), 32'd0);
    chk("rst after rom_rst", 32'(rom_rst), 32'd0);

    // Stop: in-flight samples drain, config offered with en fall applies in idle
    do_reset();
    start_run(F24, 10'd5, 2'd3);
    n = 0;
    for (int k = 0; k < 40 && n < 10; k++) begin
      step();
      if (wave_valid) n++;
    end
    chk("drop ten samples", 32'(n), 32'd10);
    chk("drop s9 out", 32'(wave_out), 32'h36);
    en = 1'b0;
    drive_cfg(1'b1, F24, 10'd9, 2'd0);
    chk("drop ready", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    drive_cfg(1'b0, F24, 10'd9, 2'd0);
    chk("drop s10 valid", 32'(wave_valid), 32'd1);
    chk("drop s10 out", 32'(wave_out), 32'h37);
    chk("drop f addr", 32'(rom_addr), 32'd5);
    step();
    chk("drop s11 valid", 32'(wave_valid), 32'd1);
    chk("drop s11 out", 32'(wave_out), 32'h30);
    chk("drop idle addr", 32'(rom_addr), 32'd9);
    step();
    chk("drop end valid", 32'(wave_valid), 32'd0);
    chk("drop end out", 32'(wave_out), 32'h80);
    chk("drop end ps", 32'(period_start), 32'd0);
    chk("drop end addr", 32'(rom_addr), 32'd9);
    n = 0;
    repeat (3) begin
      step();
      if (wave_valid) n++;
    end
    chk("drop no extra samples", 32'(n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
